rgb_fade_scheduler: RTL
=======================

Name: rgb_fade_scheduler

Overview:
- Sits between the three rotary-encoder value registers and the three PWM channels of the RGB mixer.
- Captures a set of three target levels through a valid/ready handshake.
- Either jumps the PWM levels to the targets, or fades them one LSB per step using a single shared step engine that visits the channels round-robin.
- Reports fade progress with busy and a completion pulse.

Parameters:
- WIDTH, 8: bit width of each level and target.
- TICK_DIV, 256: clock cycles between fade rounds; legal range ≥1. The tick counter is clog2(TICK_DIV) bits wide, minimum 1.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-low reset.
- target0  input  WIDTH  requested level, channel 0 (red).
- target1  input  WIDTH  requested level, channel 1 (green).
- target2  input  WIDTH  requested level, channel 2 (blue).
- fade_en  input  1  mode for this load: 1 = fade, 0 = jump. Sampled only on load acceptance.
- load_valid  input  1  requester presents targets and fade_en.
- load_ready  output  1  block can accept a load this cycle.
- level0  output  WIDTH  current level to PWM channel 0.
- level1  output  WIDTH  current level to PWM channel 1.
- level2  output  WIDTH  current level to PWM channel 2.
- busy  output  1  fade in progress (FSM not in IDLE).
- done  output  1  one-cycle pulse when a fade completes.

Behaviour:
- Reset is synchronous and active-low. While reset is low on a clock edge: level0..2 = 0, internal targets = 0, tick counter = 0, FSM = IDLE, done = 0. Loads presented while reset is low are ignored.
- Outputs while out of reset:
  - load_ready = 1 in IDLE and WAIT_TICK, 0 in STEP0/1/2.
  - busy = (state != IDLE).
  - level outputs are registers.
- Load acceptance: a load is accepted on the edge where load_valid & load_ready are both 1. All three targets are captured together.
- Jump load (fade_en = 0), accepted in any ready state:
  - level0..2 take the new targets on the same edge.
  - FSM goes to IDLE and the tick counter clears.
  - done is not pulsed. This aborts any fade in progress.
- Fade load (fade_en = 1):
  - If the new targets equal the current levels: FSM goes to IDLE, no done.
  - Otherwise, accepted from IDLE: FSM goes to WAIT_TICK and the counter clears to 0.
  - Otherwise, accepted in WAIT_TICK: only the targets are replaced. The counter continues and the state is unchanged (retarget mid-fade).
- WAIT_TICK: counter increments each cycle. When counter == TICK_DIV-1, counter goes to 0 and the next state is STEP0. A round therefore takes TICK_DIV + 3 cycles.
- STEP0, STEP1, STEP2 each last exactly one cycle. In STEPn the shared engine updates channel n only:
  - level < target: level + 1.
  - level > target: level - 1.
  - level == target: unchanged.
  - No wrap-around is possible; 0 never decrements and max never increments past the target.
- After STEP2, using the post-update levels:
  - If any level != its target: next state WAIT_TICK, counter = 0.
  - Else: next state IDLE, with done = 1 during the first IDLE cycle only.
- Latency: for a fade load accepted on edge E, WAIT_TICK covers the cycles after E through E+TICK_DIV, and the first level0 change is visible after edge E+TICK_DIV+1. A fade of maximum distance D completes in D rounds.
- Simultaneous events:
  - Reset has priority over load.
  - A load during a STEP state is not accepted; the requester must hold load_valid until ready.
  - done and load acceptance in the same cycle are permitted; the load takes effect normally.

Test Plan:
- Reset: hold reset low for 2 cycles with load_valid = 1 and targets = 0xFF → levels 0/0/0, busy 0, done 0; after release load_ready = 1 and the ignored load has not been applied.
- Jump, any TICK_DIV: load fade_en = 0, targets 10/200/255 → next cycle levels 10/200/255, busy 0, done never asserted.
- Fade up, TICK_DIV = 4, from 0/0/0, targets 3/0/1, accepted at edge 0:
  - level0 = 1 after edge 5 and level2 = 1 after edge 7.
  - level0 = 2 after edge 12 and level0 = 3 after edge 19.
  - IDLE with done = 1 for exactly one cycle after edge 21, busy 0 thereafter.
- Retarget and backpressure, TICK_DIV = 4, levels 5/5/5, fade to 0/0/0:
  - Assert a new load 8/8/8 at a STEP1 cycle → load_ready 0, load held, accepted in the following WAIT_TICK.
  - All channels reverse and reach 8/8/8 with a single done pulse.
- Abort: mid-fade (levels 2/2/2 heading to 9/9/9), jump load 100/50/0 → next cycle levels 100/50/0, busy 0, no done pulse ever from the aborted fade.
- Reset mid-fade and boundaries:
  - Reset low during STEP1 → next cycle levels 0, IDLE, no done.
  - Fade load equal to current levels (e.g. 255/255/255 at 255/255/255, or 0/0/0 at 0/0/0) → no level change, busy 0, no done, no wrap.

Source files
------------

// File: rtl/rgb_fade_scheduler.sv
// Three-channel level scheduler for the RGB mixer: captures target levels and
// either jumps to them or fades one LSB per round via a shared round-robin step engine.
module rgb_fade_scheduler #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TICK_DIV = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target0,
  input  logic [WIDTH-1:0] target1,
  input  logic [WIDTH-1:0] target2,
  input  logic             fade_en,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [WIDTH-1:0] level0,
  output logic [WIDTH-1:0] level1,
  output logic [WIDTH-1:0] level2,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    STEP0     = 3'd2,
    STEP1     = 3'd3,
    STEP2     = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] tgt0, tgt1, tgt2;

  // One LSB toward the target; never wraps because it stops on equality.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] lvl,
                                                   input logic [WIDTH-1:0] tgt);
    if (lvl < tgt)      return lvl + WIDTH'(1);
    else if (lvl > tgt) return lvl - WIDTH'(1);
    else                return lvl;
  endfunction

  logic             accept;
  logic             targets_match;
  logic [WIDTH-1:0] next_level2;

  assign load_ready    = (state == IDLE) || (state == WAIT_TICK);
  assign busy          = (state != IDLE);
  assign accept        = load_valid && load_ready;
  assign targets_match = (target0 == level0) && (target1 == level1) && (target2 == level2);
  assign next_level2   = step_toward(level2, tgt2);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      tgt0   <= '0;
      tgt1   <= '0;
      tgt2   <= '0;
      level0 <= '0;
      level1 <= '0;
      level2 <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, WAIT_TICK: begin
          if (state == WAIT_TICK) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= STEP0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          // A load overrides the tick advance above, except a mid-fade retarget.
          if (accept) begin
            tgt0 <= target0;
            tgt1 <= target1;
            tgt2 <= target2;
            if (!fade_en) begin
              level0 <= target0;
              level1 <= target1;
              level2 <= target2;
              state  <= IDLE;
              cnt    <= '0;
            end else if (targets_match) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (state == IDLE) begin
              state <= WAIT_TICK;
              cnt   <= '0;
            end
          end
        end
        STEP0: begin
          level0 <= step_toward(level0, tgt0);
          state  <= STEP1;
        end
        STEP1: begin
          level1 <= step_toward(level1, tgt1);
          state  <= STEP2;
        end
        STEP2: begin
          level2 <= next_level2;
          if ((level0 != tgt0) || (level1 != tgt1) || (next_level2 != tgt2)) begin
            state <= WAIT_TICK;
            cnt   <= '0;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
